// File: rtl/dcache_wb_buffer.sv
// dcache_wb_buffer: write-back buffer for dirty DCache victim lines.
// Victims queue up in a circular FIFO and drain one at a time as AXI INCR
// bursts. Stores can still merge into lines that have not yet been issued
// to AXI. Loads and the PTW can read any buffered line, including the line
// currently draining.
module dcache_wb_buffer #(
    parameter int DEPTH    = 4,
    parameter int PADDR_W  = 32,
    parameter int BANK     = 8,
    parameter int WORD_W   = 32,
    parameter int LK_PORTS = 2,
    localparam int OFF_W     = $clog2(BANK * WORD_W / 8),
    localparam int LINE_W    = PADDR_W - OFF_W,
    localparam int PTR_W     = $clog2(DEPTH),
    localparam int LINE_BITS = BANK * WORD_W,
    localparam int BEAT_W    = $clog2(BANK),
    localparam int BYTES     = WORD_W / 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          enq_valid,
    output logic                          enq_ready,
    input  logic [LINE_W-1:0]             enq_addr,
    input  logic [LINE_BITS-1:0]          enq_data,
    input  logic [LK_PORTS-1:0]           lk_valid,
    input  logic [LK_PORTS*LINE_W-1:0]    lk_addr,
    output logic [LK_PORTS-1:0]           lk_hit,
    output logic [LK_PORTS*LINE_BITS-1:0] lk_data,
    input  logic                          st_valid,
    input  logic [LINE_W-1:0]             st_addr,
    input  logic [BEAT_W-1:0]             st_bank,
    input  logic [WORD_W-1:0]             st_data,
    input  logic [BYTES-1:0]              st_mask,
    output logic                          st_hit,
    output logic                          st_conflict,
    output logic                          aw_valid,
    input  logic                          aw_ready,
    output logic [PADDR_W-1:0]            aw_addr,
    output logic [7:0]                    aw_len,
    output logic                          w_valid,
    input  logic                          w_ready,
    output logic [WORD_W-1:0]             w_data,
    output logic                          w_last,
    input  logic                          b_valid,
    output logic                          b_ready,
    output logic                          full,
    output logic                          empty,
    output logic [PTR_W:0]                count
);

    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BANK - 1);

    typedef enum logic [1:0] {S_IDLE, S_AW, S_W, S_B} state_t;

    state_t                 state_q, state_d;
    logic [PTR_W:0]         head_q, tail_q;
    logic [PTR_W-1:0]       head_idx, tail_idx;
    logic [DEPTH-1:0]       valid_q, issued_q;
    logic [LINE_W-1:0]      addr_q [DEPTH];
    logic [LINE_BITS-1:0]   data_q [DEPTH];
    logic [BEAT_W-1:0]      beat_q;
    logic [WORD_W-1:0]      head_words [BANK];
    logic [DEPTH-1:0]       st_match, st_wr;
    logic [LINE_BITS-1:0]   st_wmask, st_wdata;
    logic                   enq_fire, aw_fire, w_fire, b_fire;

    assign head_idx  = head_q[PTR_W-1:0];
    assign tail_idx  = tail_q[PTR_W-1:0];
    assign empty     = (head_q == tail_q);
    assign full      = (head_idx == tail_idx) && (head_q[PTR_W] != tail_q[PTR_W]);
    assign count     = tail_q - head_q;
    assign enq_ready = !full;
    assign enq_fire  = enq_valid && enq_ready;
    assign aw_fire   = aw_valid && aw_ready;
    assign w_fire    = w_valid && w_ready;
    assign b_fire    = b_valid && b_ready;

    // Split the head line into words so the current beat can be picked by index.
    always_comb begin
        for (int k = 0; k < BANK; k++) begin
            head_words[k] = data_q[head_idx][k*WORD_W +: WORD_W];
        end
    end

    // Drain FSM: next state and AXI outputs; address/data are zero when not valid.
    always_comb begin
        state_d  = state_q;
        aw_valid = 1'b0;
        aw_addr  = '0;
        aw_len   = '0;
        w_valid  = 1'b0;
        w_data   = '0;
        w_last   = 1'b0;
        b_ready  = 1'b0;
        case (state_q)
            S_IDLE: begin
                // An enqueue into an empty buffer writes the head slot, so
                // start the burst at that edge instead of a cycle later.
                if (valid_q[head_idx] || (enq_fire && empty)) begin
                    state_d = S_AW;
                end
            end
            S_AW: begin
                aw_valid = 1'b1;
                aw_addr  = {addr_q[head_idx], {OFF_W{1'b0}}};
                aw_len   = 8'(BANK - 1);
                if (aw_ready) begin
                    state_d = S_W;
                end
            end
            S_W: begin
                w_valid = 1'b1;
                w_data  = head_words[beat_q];
                w_last  = (beat_q == LAST_BEAT);
                if (w_ready && (beat_q == LAST_BEAT)) begin
                    state_d = S_B;
                end
            end
            S_B: begin
                b_ready = 1'b1;
                if (b_valid) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Drain FSM state register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Queue pointers, per-entry valid/issued bits and the beat counter.
    always_ff @(posedge clk) begin
        if (!rst) begin
            head_q   <= '0;
            tail_q   <= '0;
            valid_q  <= '0;
            issued_q <= '0;
            beat_q   <= '0;
        end else begin
            if (enq_fire) begin
                valid_q[tail_idx]  <= 1'b1;
                issued_q[tail_idx] <= 1'b0;
                tail_q             <= tail_q + 1'b1;
            end
            if (aw_fire) begin
                issued_q[head_idx] <= 1'b1;
                beat_q             <= '0;
            end
            if (w_fire) begin
                beat_q <= beat_q + 1'b1;
            end
            if (b_fire) begin
                valid_q[head_idx]  <= 1'b0;
                issued_q[head_idx] <= 1'b0;
                head_q             <= head_q + 1'b1;
            end
        end
    end

    // Store merge: a hit on an unissued line merges; a hit on the issued head conflicts.
    always_comb begin
        st_wmask = '0;
        st_wdata = {BANK{st_data}};
        for (int i = 0; i < DEPTH; i++) begin
            st_match[i] = valid_q[i] && (addr_q[i] == st_addr);
        end
        st_wr       = st_valid ? (st_match & ~issued_q) : '0;
        st_hit      = |st_wr;
        st_conflict = st_valid && |(st_match & issued_q);
        for (int k = 0; k < BANK; k++) begin
            for (int b = 0; b < BYTES; b++) begin
                if ((st_bank == BEAT_W'(k)) && st_mask[b]) begin
                    st_wmask[k*WORD_W + b*8 +: 8] = 8'hFF;
                end
            end
        end
    end

    // Line storage: enqueue fills the tail slot, merged stores patch selected bytes.
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (enq_fire && (tail_idx == PTR_W'(i))) begin
                addr_q[i] <= enq_addr;
                data_q[i] <= enq_data;
            end else if (st_wr[i]) begin
                data_q[i] <= (data_q[i] & ~st_wmask) | (st_wdata & st_wmask);
            end
        end
    end

    // Lookup ports: OR together matching entries (at most one matches), zero on miss.
    always_comb begin
        lk_hit  = '0;
        lk_data = '0;
        for (int p = 0; p < LK_PORTS; p++) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (lk_valid[p] && valid_q[i] && (addr_q[i] == lk_addr[p*LINE_W +: LINE_W])) begin
                    lk_hit[p] = 1'b1;
                    lk_data[p*LINE_BITS +: LINE_BITS] = lk_data[p*LINE_BITS +: LINE_BITS] | data_q[i];
                end
            end
        end
    end

endmodule

// File: tb/tb_dcache_wb_buffer.sv
// tb_dcache_wb_buffer: directed self-checking bench for dcache_wb_buffer
// with default parameters (DEPTH=4, BANK=8, WORD_W=32, 27-bit line address).
module tb_dcache_wb_buffer;

    logic         clk;
    logic         rst;
    logic         enq_valid;
    logic         enq_ready;
    logic [26:0]  enq_addr;
    logic [255:0] enq_data;
    logic [1:0]   lk_valid;
    logic [53:0]  lk_addr;
    logic [1:0]   lk_hit;
    logic [511:0] lk_data;
    logic         st_valid;
    logic [26:0]  st_addr;
    logic [2:0]   st_bank;
    logic [31:0]  st_data;
    logic [3:0]   st_mask;
    logic         st_hit;
    logic         st_conflict;
    logic         aw_valid;
    logic         aw_ready;
    logic [31:0]  aw_addr;
    logic [7:0]   aw_len;
    logic         w_valid;
    logic         w_ready;
    logic [31:0]  w_data;
    logic         w_last;
    logic         b_valid;
    logic         b_ready;
    logic         full;
    logic         empty;
    logic [2:0]   count;

    int n_cmp  = 0;
    int n_fail = 0;

    dcache_wb_buffer dut (
        .clk(clk), .rst(rst),
        .enq_valid(enq_valid), .enq_ready(enq_ready), .enq_addr(enq_addr), .enq_data(enq_data),
        .lk_valid(lk_valid), .lk_addr(lk_addr), .lk_hit(lk_hit), .lk_data(lk_data),
        .st_valid(st_valid), .st_addr(st_addr), .st_bank(st_bank), .st_data(st_data),
        .st_mask(st_mask), .st_hit(st_hit), .st_conflict(st_conflict),
        .aw_valid(aw_valid), .aw_ready(aw_ready), .aw_addr(aw_addr), .aw_len(aw_len),
        .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data), .w_last(w_last),
        .b_valid(b_valid), .b_ready(b_ready),
        .full(full), .empty(empty), .count(count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard stop in case a bounded wait is broken.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    typedef struct {
        logic        enq_v, aw_r, w_r, b_v;
        logic        exp_aw_v;
        logic [31:0] exp_aw_addr;
        logic        exp_w_v;
        logic [31:0] exp_w_data;
        logic        exp_w_last;
        logic        exp_b_r;
        logic [2:0]  exp_count;
        logic        exp_empty;
    } vec_t;

    vec_t vecs [13];

    function automatic vec_t make_vec(input logic ev, ar, wr, bv, eaw, input logic [31:0] eaa,
                                      input logic ewv, input logic [31:0] ewd,
                                      input logic ewl, ebr, input logic [2:0] ec, input logic ee);
        vec_t v;
        v.enq_v = ev; v.aw_r = ar; v.w_r = wr; v.b_v = bv;
        v.exp_aw_v = eaw; v.exp_aw_addr = eaa; v.exp_w_v = ewv; v.exp_w_data = ewd;
        v.exp_w_last = ewl; v.exp_b_r = ebr; v.exp_count = ec; v.exp_empty = ee;
        return v;
    endfunction

    // Line whose word k is {seed, k}.
    function automatic logic [255:0] mkline(input logic [15:0] seed);
        logic [255:0] r;
        for (int k = 0; k < 8; k++) r[k*32 +: 32] = {seed, 16'(k)};
        return r;
    endfunction

    task automatic check_output(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check_output({tag, " enq_ready"}, enq_ready, 1'b1);
        check_output({tag, " empty"}, empty, 1'b1);
        check_output({tag, " full"}, full, 1'b0);
        check_output({tag, " count"}, count, 3'd0);
        check_output({tag, " aw_valid"}, aw_valid, 1'b0);
        check_output({tag, " w_valid"}, w_valid, 1'b0);
        check_output({tag, " w_last"}, w_last, 1'b0);
        check_output({tag, " b_ready"}, b_ready, 1'b0);
        check_output({tag, " aw_addr"}, aw_addr, 32'd0);
        check_output({tag, " aw_len"}, aw_len, 8'd0);
        check_output({tag, " w_data"}, w_data, 32'd0);
        check_output({tag, " lk_hit"}, lk_hit, 2'b00);
        check_output({tag, " lk_data"}, lk_data[255:0], 256'd0);
        check_output({tag, " st_hit"}, st_hit, 1'b0);
        check_output({tag, " st_conflict"}, st_conflict, 1'b0);
    endtask

    // Checks eight beats starting in the current cycle; w_ready must already be 1.
    task automatic check_beats(input logic [255:0] ld, input string tag);
        for (int k = 0; k < 8; k++) begin
            check_output($sformatf("%s beat%0d w_valid", tag, k), w_valid, 1'b1);
            check_output($sformatf("%s beat%0d w_data", tag, k), w_data, ld[k*32 +: 32]);
            check_output($sformatf("%s beat%0d w_last", tag, k), w_last, (k == 7));
            tick();
        end
    endtask

    // Drains the head line with ready/response always asserted and checks it.
    task automatic drain_line(input logic [26:0] la, input logic [255:0] ld, input string tag);
        int n;
        aw_ready = 1'b1; w_ready = 1'b1; b_valid = 1'b1;
        #1;
        n = 0;
        while (!aw_valid && n < 40) begin
            tick();
            n++;
        end
        check_output({tag, " aw wait in budget"}, (n < 40), 1'b1);
        check_output({tag, " aw_addr"}, aw_addr, {la, 5'b0});
        check_output({tag, " aw_len"}, aw_len, 8'd7);
        tick();
        check_beats(ld, tag);
        check_output({tag, " b_ready"}, b_ready, 1'b1);
        tick();
        aw_ready = 1'b0; w_ready = 1'b0; b_valid = 1'b0;
    endtask

    initial begin
        logic [255:0] la_data, merged;
        int n;

        rst = 1'b0; enq_valid = 0; enq_addr = '0; enq_data = '0;
        lk_valid = '0; lk_addr = '0; st_valid = 0; st_addr = '0; st_bank = '0;
        st_data = '0; st_mask = '0; aw_ready = 0; w_ready = 0; b_valid = 0;
        repeat (2) tick();
        check_reset_outputs("reset");
        rst = 1'b1;

        // Single line, cycle by cycle: enqueue, AW, 8 beats, B two cycles after w_last.
        vecs[0]  = make_vec(1, 1, 1, 0, 0, 32'h0, 0, 32'h0, 0, 0, 3'd0, 1);
        vecs[1]  = make_vec(0, 1, 1, 0, 1, 32'h0004_0000, 0, 32'h0, 0, 0, 3'd1, 0);
        for (int k = 0; k < 8; k++)
            vecs[2+k] = make_vec(0, 1, 1, 0, 0, 32'h0, 1, 32'hCAFE_0000 + k, (k == 7), 0, 3'd1, 0);
        vecs[10] = make_vec(0, 1, 1, 0, 0, 32'h0, 0, 32'h0, 0, 1, 3'd1, 0);
        vecs[11] = make_vec(0, 1, 1, 1, 0, 32'h0, 0, 32'h0, 0, 1, 3'd1, 0);
        vecs[12] = make_vec(0, 1, 1, 0, 0, 32'h0, 0, 32'h0, 0, 0, 3'd0, 1);
        enq_addr = 27'h000_2000;
        enq_data = mkline(16'hCAFE);
        for (int r = 0; r < 13; r++) begin
            enq_valid = vecs[r].enq_v; aw_ready = vecs[r].aw_r;
            w_ready = vecs[r].w_r; b_valid = vecs[r].b_v;
            #1;
            check_output($sformatf("row%0d aw_valid", r), aw_valid, vecs[r].exp_aw_v);
            check_output($sformatf("row%0d aw_addr", r), aw_addr, vecs[r].exp_aw_addr);
            check_output($sformatf("row%0d w_valid", r), w_valid, vecs[r].exp_w_v);
            check_output($sformatf("row%0d w_data", r), w_data, vecs[r].exp_w_data);
            check_output($sformatf("row%0d w_last", r), w_last, vecs[r].exp_w_last);
            check_output($sformatf("row%0d b_ready", r), b_ready, vecs[r].exp_b_r);
            check_output($sformatf("row%0d count", r), count, vecs[r].exp_count);
            check_output($sformatf("row%0d empty", r), empty, vecs[r].exp_empty);
            tick();
        end
        aw_ready = 0; w_ready = 0; b_valid = 0;

        // Full and wrap: four lines fill the buffer while AW is stalled.
        for (int i = 0; i < 4; i++) begin
            enq_valid = 1'b1;
            enq_addr  = 27'h100 + 27'(i);
            enq_data  = mkline(16'hA000 + 16'(i));
            #1;
            check_output($sformatf("fill%0d enq_ready", i), enq_ready, 1'b1);
            tick();
        end
        enq_addr = 27'h104;
        enq_data = mkline(16'hA004);
        #1;
        check_output("full enq_ready", enq_ready, 1'b0);
        check_output("full flag", full, 1'b1);
        check_output("full count", count, 3'd4);
        drain_line(27'h100, mkline(16'hA000), "wrap0");
        check_output("after B count no bypass", count, 3'd3);
        check_output("after B enq_ready", enq_ready, 1'b1);
        tick();
        enq_valid = 1'b0;
        #1;
        check_output("fifth accepted count", count, 3'd4);
        for (int i = 1; i < 5; i++)
            drain_line(27'h100 + 27'(i), mkline(16'hA000 + 16'(i)), $sformatf("wrap%0d", i));
        check_output("wrap drained empty", empty, 1'b1);
        check_output("wrap drained count", count, 3'd0);

        // Store merge; a store in the enqueue cycle must not merge.
        enq_valid = 1'b1; enq_addr = 27'h0A0; enq_data = mkline(16'h5555);
        st_valid = 1'b1; st_addr = 27'h0A0; st_bank = 3'd3; st_mask = 4'b1111; st_data = 32'h1122_3344;
        #1;
        check_output("st same-cycle enq st_hit", st_hit, 1'b0);
        tick();
        enq_valid = 1'b0;
        st_mask = 4'b0101; st_data = 32'hAABB_CCDD;
        #1;
        check_output("merge st_hit", st_hit, 1'b1);
        check_output("merge st_conflict", st_conflict, 1'b0);
        tick();
        st_addr = 27'h0B0;
        #1;
        check_output("miss st_hit", st_hit, 1'b0);
        check_output("miss st_conflict", st_conflict, 1'b0);
        st_valid = 1'b0;
        merged = mkline(16'h5555);
        merged[3*32 +: 32] = 32'h55BB_00DD;
        drain_line(27'h0A0, merged, "merge");

        // Store to an already-issued head conflicts and leaves data alone.
        enq_valid = 1'b1; enq_addr = 27'h0C0; enq_data = mkline(16'h7777);
        aw_ready = 1'b1; w_ready = 1'b0;
        tick();
        enq_valid = 1'b0;
        tick();
        aw_ready = 1'b0;
        st_valid = 1'b1; st_addr = 27'h0C0; st_bank = 3'd0; st_mask = 4'b1111; st_data = 32'hDEAD_BEEF;
        #1;
        check_output("issued st_conflict", st_conflict, 1'b1);
        check_output("issued st_hit", st_hit, 1'b0);
        tick();
        st_valid = 1'b0; w_ready = 1'b1;
        #1;
        check_beats(mkline(16'h7777), "issued");
        b_valid = 1'b1;
        #1;
        check_output("issued b_ready", b_ready, 1'b1);
        tick();
        b_valid = 1'b0; w_ready = 1'b0;

        // Lookup: port 0 hits a draining line until B completes, port 1 misses.
        la_data = mkline(16'h3333);
        enq_valid = 1'b1; enq_addr = 27'h0D0; enq_data = la_data;
        aw_ready = 1'b1; w_ready = 1'b1; b_valid = 1'b0;
        lk_valid = 2'b11; lk_addr = {27'h0E0, 27'h0D0};
        #1;
        check_output("lk enq-cycle lk_hit", lk_hit, 2'b00);
        tick();
        enq_valid = 1'b0;
        n = 0;
        while (!b_ready && n < 20) begin
            #1;
            check_output($sformatf("lk drain%0d lk_hit", n), lk_hit, 2'b01);
            tick();
            n++;
        end
        check_output("lk b wait in budget", (n < 20), 1'b1);
        b_valid = 1'b1;
        #1;
        check_output("lk B-cycle lk_hit", lk_hit, 2'b01);
        check_output("lk B-cycle data0", lk_data[255:0], la_data);
        check_output("lk B-cycle data1", lk_data[511:256], 256'd0);
        tick();
        b_valid = 1'b0;
        #1;
        check_output("lk after B lk_hit", lk_hit, 2'b00);
        check_output("lk after B data0", lk_data[255:0], 256'd0);
        lk_valid = 2'b00;

        // Mid-burst reset during beat 4.
        enq_valid = 1'b1; enq_addr = 27'h0F0; enq_data = mkline(16'h9999);
        aw_ready = 1'b1; w_ready = 1'b1;
        tick();
        enq_valid = 1'b0;
        repeat (5) tick();
        check_output("midreset beat4 w_data", w_data, 32'h9999_0004);
        rst = 1'b0;
        tick();
        check_reset_outputs("midreset");
        rst = 1'b1; aw_ready = 1'b0; w_ready = 1'b0;
        tick();
        check_output("post reset aw_valid", aw_valid, 1'b0);
        check_output("post reset empty", empty, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/dcache_wb_buffer.md
# dcache_wb_buffer

Parametrised write-back buffer between the DCache refill path and the AXI write channel. It accepts dirty victim lines evicted on refill and drains them to memory as AXI INCR bursts, one outstanding line at a time. It extends the fixed-size replace queue with configurable depth, line size and lookup-port count. It also adds store coalescing into not-yet-issued victims and line forwarding for loads and PTW.

## Interface

Parameters:
- DEPTH, 4: number of line entries, power of two, ≥2
- PADDR_W, 32: physical address width
- BANK, 8: words per line, power of two
- WORD_W, 32: bits per word; also the AXI W data width
- LK_PORTS, 2: load/PTW lookup ports
- Derived: OFF_W = log2(BANK*WORD_W/8); LINE_W = PADDR_W-OFF_W; PTR_W = log2(DEPTH)

Ports:
- clk  in  1  clock. One clock; reset is synchronous and active-low.
- rst  in  1  synchronous reset, active-low (0 = reset)
- enq_valid  in  1  victim line offered
- enq_ready  out  1  entry free (registered count < DEPTH)
- enq_addr  in  LINE_W  victim line address
- enq_data  in  BANK*WORD_W  victim line data, bank 0 in LSBs
- lk_valid  in  LK_PORTS  lookup request per port
- lk_addr  in  LK_PORTS*LINE_W  lookup line address
- lk_hit  out  LK_PORTS  line present (any valid entry, including draining)
- lk_data  out  LK_PORTS*BANK*WORD_W  matching entry data
- st_valid  in  1  store merge request
- st_addr  in  LINE_W  store line address
- st_bank  in  log2(BANK)  word index
- st_data  in  WORD_W  store data
- st_mask  in  WORD_W/8  byte mask
- st_hit  out  1  store merged (combinational)
- st_conflict  out  1  store matches an entry already issued to AXI
- aw_valid/aw_ready  out/in  1  AXI write address handshake
- aw_addr  out  PADDR_W  {line, OFF_W zeros}
- aw_len  out  8  BANK-1
- w_valid/w_ready  out/in  1  AXI write data handshake
- w_data  out  WORD_W  current beat
- w_last  out  1  final beat
- b_valid  in  1  write response
- b_ready  out  1  write response accepted
- full, empty  out  1  status
- count  out  PTR_W+1  occupied entries

## Operation

- Storage: circular FIFO. Head/tail pointers are PTR_W+1 bits; the MSB is the wrap bit. Empty when pointers are equal; full when the low bits are equal and the MSBs differ.
- Per-entry valid, issued, line address, data.
- Enqueue: enq_valid & enq_ready writes the tail entry with valid=1 and issued=0, then advances tail.
- The caller guarantees an enqueued address is not already valid in the buffer.

Drain FSM on the head entry: IDLE → AW → W → B → IDLE.
- IDLE: moves to AW when the head entry is valid.
- AW: aw_valid=1. On aw_ready, sets the head issued bit, clears the beat counter and moves to W.
- W: w_valid=1; w_data = data[beat]; w_last = (beat==BANK-1). Each w_ready increments beat. On the last beat moves to B.
- B: b_ready=1. On b_valid, clears head valid, advances head, returns to IDLE. BRESP is ignored.

Lookup:
- Each port is compared against all valid entries; lk_hit = lk_valid & match.
- lk_data is the matching entry's data; zero on miss.
- Draining entries still hit until B completes.

Store merge:
- A match against a valid entry with issued=0 gives st_hit=1. Bytes of data[st_bank] selected by st_mask are written at the clock edge.
- A match against the issued head entry gives st_conflict=1, st_hit=0, and no write.
- A miss gives both outputs 0.

Simultaneous events:
- Enqueue with B completion while full: enq_ready is from registered count, so it stays 0 and no bypass occurs.
- Store to the entry being enqueued in the same cycle: not merged (entry not yet valid).
- Store to the head entry in the same cycle as aw_ready: merged, because issued is still 0 that cycle; the data is written before the first W beat.
- Lookup in the B-completion cycle still hits.

Reset (rst=0 at the edge):
- Pointers, valid bits, FSM state and beat counter are cleared.
- Any in-flight AXI transaction is abandoned.

## Timing

- Reset values: enq_ready=1, empty=1, full=0, count=0. aw_valid, w_valid, w_last, b_ready, lk_hit, st_hit and st_conflict are 0; aw_addr, aw_len, w_data and lk_data are 0.
- aw_valid asserts the cycle after the enqueue edge of an entry into an empty buffer.
- The first W beat is offered the cycle after the AW handshake. With w_ready held at 1, BANK beats take BANK cycles.
- The entry is freed at the b_valid edge; enq_ready rises the next cycle if the buffer was full.
- AXI valids are held until the handshake; address and data are stable while valid.
- lk_*, st_hit and st_conflict are combinational, same cycle.

## Test plan

- Single line: enqueue addr 0x0004_0, data words 0..7, BANK=8; aw_ready=w_ready=1, b_valid 2 cycles after w_last. Required: aw_addr=0x0004_0000, aw_len=7, beats 0..7 with w_last on beat 7, then empty=1 and count=0.
- Full/wrap: enqueue 5 lines with DEPTH=4, aw_ready=0. Required: enq_ready=0 after 4 lines. Release AW/W/B: drained in order, tail wraps, the 5th line is accepted only the cycle after the first B.
- Store merge: enqueue line A, aw_ready=0; store to A, bank 3, mask 4'b0101, data 0xAABBCCDD. Required: st_hit=1, and beat 3 carries the merged bytes 0xBB and 0xDD.
- Store to issued line: store to the head after the AW handshake. Required: st_conflict=1, st_hit=0, drained data unchanged.
- Lookup: two ports query A (a draining entry) and B (absent). Required: lk_hit=2'b01 and lk_data[0]=A data, holding until the B-response cycle; lk_hit drops the cycle after.
- Mid-burst reset: drive rst=0 during beat 4. Required: the next cycle shows all outputs at reset values and count=0.
